// File: rtl/csa_sub16_seq.sv
// Slice-serial subtractor: diff = a - b - borrow_in computed as a + ~b + ~borrow_in,
// one carry-select SLICE-bit group per clock, with valid/ready handshakes on both sides.
module csa_sub16_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CntW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned Msb    = WIDTH - 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic [WIDTH-1:0] diff_q, diff_wr;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic [SLICE-1:0] a_sl  [NSLICE];
  logic [SLICE-1:0] nb_sl [NSLICE];
  logic [SLICE-1:0] a_k, nb_k, sel_s;
  logic [SLICE:0]   sum0, sum1;
  logic             sel_c, calc_last;

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    assign a_sl[k]  = a_q[k*SLICE +: SLICE];
    assign nb_sl[k] = nb_q[k*SLICE +: SLICE];
    // Only the slice addressed by the counter is overwritten; others hold.
    assign diff_wr[k*SLICE +: SLICE] = (state_q == StCalc && cnt_q == CntW'(k)) ?
                                       sel_s : diff_q[k*SLICE +: SLICE];
  end

  // Both carry-in candidates are formed up front; the running carry picks one.
  assign a_k   = a_sl[cnt_q];
  assign nb_k  = nb_sl[cnt_q];
  assign sum0  = {1'b0, a_k} + {1'b0, nb_k};
  assign sum1  = {1'b0, a_k} + {1'b0, nb_k} + (SLICE+1)'(1);
  assign sel_s = carry_q ? sum1[SLICE-1:0] : sum0[SLICE-1:0];
  assign sel_c = carry_q ? sum1[SLICE] : sum0[SLICE];

  assign calc_last = (cnt_q == CntW'(NSLICE - 1));

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    nb_d       = nb_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          nb_d    = ~b;
          carry_d = ~borrow_in;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        carry_d = sel_c;
        cnt_d   = cnt_q + CntW'(1);
        if (calc_last) begin
          cnt_d      = '0;
          state_d    = StDone;
          borrow_d   = ~sel_c;
          // b's sign bit is the complement of the stored ~b sign bit.
          overflow_d = (a_q[Msb] == nb_q[Msb]) && (diff_wr[Msb] != a_q[Msb]);
          zero_d     = (diff_wr == '0);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      a_q        <= '0;
      nb_q       <= '0;
      diff_q     <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      nb_q       <= nb_d;
      diff_q     <= diff_wr;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign overflow   = overflow_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_csa_sub16_seq.sv
// Self-checking bench for csa_sub16_seq: directed corner cases plus randomized operands,
// checked against an integer-arithmetic reference model.
module tb_csa_sub16_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        borrow_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        borrow_out, overflow, zero;

  int n_cmp = 0;
  int n_err = 0;

  csa_sub16_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .borrow_in (borrow_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow_out(borrow_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  // One full transaction; hold = cycles of backpressure after out_valid rises.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                        input int hold, input bit poke);
    int          cyc;
    int          sd;
    logic [15:0] e_diff;
    logic        e_bo, e_ov, e_z;
    sd     = int'($signed(ta)) - int'($signed(tb)) - int'(tbin);
    e_diff = 16'(int'(ta) - int'(tb) - int'(tbin));
    e_bo   = int'(ta) < (int'(tb) + int'(tbin));
    e_ov   = (sd < -32768) || (sd > 32767);
    e_z    = (e_diff == 16'h0);

    wait_ready();
    a         = ta;
    b         = tb;
    borrow_in = tbin;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    a         = 16'($urandom);
    b         = 16'($urandom);
    borrow_in = 1'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("latency", 32'(cyc), 32'd4);
    check_eq("diff", 32'(diff), 32'(e_diff));
    check_eq("borrow_out", 32'(borrow_out), 32'(e_bo));
    check_eq("overflow", 32'(overflow), 32'(e_ov));
    check_eq("zero", 32'(zero), 32'(e_z));
    check_eq("in_ready_busy", 32'(in_ready), 32'd0);

    for (int i = 0; i < hold; i++) begin
      in_valid = poke;
      @(negedge clk);
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_ready", 32'(in_ready), 32'd0);
      check_eq("hold_flags", {13'd0, borrow_out, overflow, zero, diff},
               {13'd0, e_bo, e_ov, e_z, e_diff});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("post_hs_valid", 32'(out_valid), 32'd0);
    check_eq("post_hs_ready", 32'(in_ready), 32'd1);
  endtask

  function automatic logic [15:0] pick_val();
    logic [15:0] corners [6];
    corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h1000};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return 16'($urandom);
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    borrow_in = 1'b0;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_outputs", {13'd0, borrow_out, overflow, zero, diff}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'h1234, 16'h0034, 1'b0, 0, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h0005, 16'h0004, 1'b1, 0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 0, 1'b0);
    run_op(16'h1000, 16'h0001, 1'b0, 0, 1'b0);
    // Backpressure with in_valid asserted throughout the hold.
    run_op(16'hBEEF, 16'h1234, 1'b1, 10, 1'b1);
    @(negedge clk);
    check_eq("no_reaccept", 32'(out_valid), 32'd0);

    // Abort mid-calculation.
    wait_ready();
    a        = 16'hFFFF;
    b        = 16'h0001;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_out_valid", 32'(out_valid), 32'd0);
    check_eq("abort_in_ready", 32'(in_ready), 32'd1);
    check_eq("abort_diff", 32'(diff), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'h0003, 16'h0001, 1'b0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      run_op(pick_val(), pick_val(), 1'($urandom), int'($urandom_range(0, 3)),
             1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
